core_sequencer: RTL and testbench
=================================

# core_sequencer

Frame-level controller that sequences the MNIST accelerator core for one image at a time. It accepts a start command, clears the core, streams exactly `NUM_PIXELS` pixels from an upstream ready/valid source into the core's `i_valid`/`pixel` inputs, and waits for the core's `o_valid`/`digit` result. It returns the classified digit, or a timeout flag, on a held ready/valid result port. It sits between the pixel buffer/DMA and the core; the core itself has no backpressure, so this block is the only throttle on the core.

## Interface
- `DATA_WIDTH`, 8, pixel width; must match the core's pixel width.
- `NUM_PIXELS`, 784, pixels per frame (28x28).
- `CLEAR_CYCLES`, 2, cycles `core_rst` is held high before streaming; minimum 1.
- `TIMEOUT_CYCLES`, 4096, maximum WAIT cycles after the last pixel before a timeout is declared.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle (or level) request to begin a frame; sampled only in IDLE.
- `abort` input 1: cancels the frame in any non-IDLE state.
- `s_valid` input 1: upstream pixel valid.
- `s_ready` output 1: pixel accepted when `s_valid && s_ready`.
- `s_pixel` input DATA_WIDTH: upstream pixel.
- `core_rst` output 1: active-high synchronous reset to the core.
- `core_i_valid` output 1: pixel strobe to the core.
- `core_pixel` output DATA_WIDTH: pixel to the core.
- `core_o_valid` input 1: core result valid.
- `core_digit` input 4: core result digit.
- `m_valid` output 1: result valid; held until accepted.
- `m_ready` input 1: downstream accepts the result.
- `m_digit` output 4: classified digit, or 4'hF on timeout.
- `m_timeout` output 1: qualifies `m_digit` as a timeout result.
- `busy` output 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE -> CLEAR on `start`.
  - CLEAR -> STREAM after `CLEAR_CYCLES` cycles.
  - STREAM -> WAIT after pixel `NUM_PIXELS-1` is accepted.
  - WAIT -> RESULT on `core_o_valid` or on timeout.
  - RESULT -> IDLE on `m_ready`.
- CLEAR: `core_rst`=1. Clear counter counts 0..CLEAR_CYCLES-1.
- STREAM: `s_ready`=1. Pixel counter `pix_cnt`, width clog2(NUM_PIXELS+1), starts at 0 and increments on each accepted pixel.
  - Each accepted pixel is registered into `core_pixel`, with `core_i_valid`=1 for exactly one cycle.
  - Cycles with no handshake produce `core_i_valid`=0; `core_pixel` holds its last value.
- WAIT: `s_ready`=0. Wait counter starts at 0 on entry and increments each cycle.
  - `core_o_valid`=1: latch `core_digit` into `m_digit`, `m_timeout`=0.
  - Otherwise, when the wait counter reaches TIMEOUT_CYCLES-1: `m_digit`=4'hF, `m_timeout`=1.
  - If `core_o_valid` and the timeout occur in the same cycle, the valid result wins.
- RESULT: `m_valid`=1. `m_digit` and `m_timeout` are stable until the `m_valid && m_ready` cycle, then return to IDLE.
- `core_o_valid` outside WAIT is ignored; it is not latched and does not change state.
- `abort` in CLEAR, STREAM, WAIT or RESULT:
  - next state IDLE;
  - `core_rst`=1 for one cycle;
  - `m_valid`=0 and counters cleared;
  - no result is produced.
- `abort` takes priority over every other transition, including the RESULT handshake.
- `start` outside IDLE is ignored; it is not queued.
- `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, all counters 0, and these outputs all 0: `s_ready`, `core_rst`, `core_i_valid`, `core_pixel`, `m_valid`, `m_digit`, `m_timeout`, `busy`.
- Reset asserted mid-frame drops all outputs to 0 immediately, without waiting for a clock edge. The next frame's CLEAR re-initialises the core.
- `start` high in IDLE at cycle 0:
  - `busy` and `core_rst` are 1 in cycles 1..CLEAR_CYCLES;
  - `s_ready`=1 from cycle CLEAR_CYCLES+1.
- Pixel accepted at cycle t -> `core_i_valid`=1 at cycle t+1 (one register stage).
- Last pixel accepted at cycle t -> `s_ready`=0 at t+1 (state is WAIT at t+1).
- `core_o_valid` at cycle w (in WAIT) -> `m_valid`=1 at w+1.
- Timeout: with no `core_o_valid`, `m_valid`=1 with `m_timeout`=1 exactly TIMEOUT_CYCLES+1 cycles after entering WAIT.
- Handshake at cycle h -> `m_valid`=0 and `busy`=0 at h+1. A `start` at h+1 is honoured.
- Minimum frame: CLEAR_CYCLES + NUM_PIXELS + 2 cycles, plus the core latency.
- `s_ready` is a registered state decode. No combinational path from `s_valid` or `m_ready` to any output.

## Test plan
- Nominal frame:
  - stimulus: NUM_PIXELS=4, CLEAR_CYCLES=2; `start`; pixels 8'h11, 8'h22, 8'h33, 8'h44 with `s_valid` held high; core model returns digit 7 three cycles after its last `i_valid`;
  - required: `core_rst` high for 2 cycles; four one-cycle `core_i_valid` pulses carrying 11, 22, 33, 44 in order; `m_valid`=1, `m_digit`=7, `m_timeout`=0 one cycle after `core_o_valid`.
- Upstream stalls: `s_valid` toggles 1,0,0,1,0,1,1 -> exactly 4 `core_i_valid` pulses, each one cycle after its handshake; no pulse in stall cycles.
- Timeout:
  - stimulus: TIMEOUT_CYCLES=16; core never asserts `o_valid`;
  - required: `m_valid`=1, `m_digit`=4'hF, `m_timeout`=1 exactly 17 cycles after WAIT entry.
  - Variant: `core_o_valid` in the timeout cycle with digit 3 -> `m_digit`=3, `m_timeout`=0.
- Result backpressure: `m_ready`=0 for 10 cycles, then 1 -> `m_valid` and `m_digit` stable for all 10 cycles; IDLE on the next cycle.
  - `start` pulsed during RESULT is ignored.
  - `start` one cycle after the handshake begins a new CLEAR.
- Abort:
  - `abort` after pixel 2 of 4 -> next cycle IDLE, `core_rst` one-cycle pulse, `s_ready`=0, no `m_valid`;
  - a following `start` runs a full 4-pixel frame correctly.
- Async reset: `rst_n` low mid-STREAM -> all outputs 0 without a clock edge; after release `busy`=0 and `start` runs a normal frame.

Source files
------------

// File: rtl/core_sequencer.sv
// Frame sequencer for the MNIST core: clears the core, streams one frame of pixels,
// then returns the classified digit (or a timeout marker) on a held result port.
module core_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_PIXELS     = 784,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_pixel,
    output logic                  core_rst,
    output logic                  core_i_valid,
    output logic [DATA_WIDTH-1:0] core_pixel,
    input  logic                  core_o_valid,
    input  logic [3:0]            core_digit,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [3:0]            m_digit,
    output logic                  m_timeout,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    // Handshakes: a pixel moves on a clock edge where s_valid && s_ready; a result
    // moves where m_valid && m_ready. Valid sides hold their data until that edge.

    localparam int PIX_W  = $clog2(NUM_PIXELS + 1);
    localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  core_rst_q, core_rst_d;
    logic                  core_i_valid_q, core_i_valid_d;
    logic [DATA_WIDTH-1:0] core_pixel_q, core_pixel_d;
    logic                  m_valid_q, m_valid_d;
    logic [3:0]            m_digit_q, m_digit_d;
    logic                  m_timeout_q, m_timeout_d;
    logic                  busy_q, busy_d;
    logic                  pix_hs;
    logic                  aborting;

    assign pix_hs   = s_valid && s_ready_q;
    assign aborting = abort && (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        core_i_valid_d = 1'b0;
        core_pixel_d   = core_pixel_q;
        m_valid_d      = m_valid_q;
        m_digit_d      = m_digit_q;
        m_timeout_d    = m_timeout_q;

        case (state_q)
            S_IDLE: begin
                clr_cnt_d = '0;
                if (start && !abort) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d   = S_STREAM;
                    clr_cnt_d = '0;
                    pix_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (pix_hs) begin
                    core_pixel_d   = s_pixel;
                    core_i_valid_d = 1'b1;
                    if (pix_cnt_q == PIX_W'(NUM_PIXELS - 1)) begin
                        state_d    = S_WAIT;
                        pix_cnt_d  = '0;
                        wait_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A real result in the final wait cycle beats the timeout.
                if (core_o_valid) begin
                    m_digit_d   = core_digit;
                    m_timeout_d = 1'b0;
                    m_valid_d   = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_RESULT;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    m_digit_d   = 4'hF;
                    m_timeout_d = 1'b1;
                    m_valid_d   = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_RESULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (aborting) begin
            state_d        = S_IDLE;
            clr_cnt_d      = '0;
            pix_cnt_d      = '0;
            wait_cnt_d     = '0;
            core_i_valid_d = 1'b0;
            m_valid_d      = 1'b0;
        end

        core_rst_d = (state_d == S_CLEAR) || aborting;
        s_ready_d  = (state_d == S_STREAM);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            clr_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            s_ready_q      <= 1'b0;
            core_rst_q     <= 1'b0;
            core_i_valid_q <= 1'b0;
            core_pixel_q   <= '0;
            m_valid_q      <= 1'b0;
            m_digit_q      <= 4'h0;
            m_timeout_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            s_ready_q      <= s_ready_d;
            core_rst_q     <= core_rst_d;
            core_i_valid_q <= core_i_valid_d;
            core_pixel_q   <= core_pixel_d;
            m_valid_q      <= m_valid_d;
            m_digit_q      <= m_digit_d;
            m_timeout_q    <= m_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign core_rst     = core_rst_q;
    assign core_i_valid = core_i_valid_q;
    assign core_pixel   = core_pixel_q;
    assign m_valid      = m_valid_q;
    assign m_digit      = m_digit_q;
    assign m_timeout    = m_timeout_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of frames plus hand-written abort, IDLE
// start/abort and asynchronous reset sequences.
module tb_core_sequencer;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int CC = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_pixel = '0;
  logic          core_rst;
  logic          core_i_valid;
  logic [DW-1:0] core_pixel;
  logic          core_o_valid = 1'b0;
  logic [3:0]    core_digit = 4'h0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [3:0]    m_digit;
  logic          m_timeout;
  logic          busy;
  logic [2:0]    dbg_state;

  core_sequencer #(
    .DATA_WIDTH(DW), .NUM_PIXELS(NP), .CLEAR_CYCLES(CC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .core_rst(core_rst), .core_i_valid(core_i_valid), .core_pixel(core_pixel),
    .core_o_valid(core_o_valid), .core_digit(core_digit),
    .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit), .m_timeout(m_timeout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ipulse_cnt = 0;

  logic [DW-1:0] pix_exp_q[$];
  logic [4:0]    res_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pixel scoreboard: every core strobe must match the next accepted pixel
  always @(negedge clk) begin
    if (rst_n && core_i_valid) begin
      ipulse_cnt++;
      checks++;
      if (pix_exp_q.size() == 0) begin
        errors++;
        $display("FAIL core_pixel: unexpected strobe with %0h", core_pixel);
      end else begin
        logic [DW-1:0] e;
        e = pix_exp_q.pop_front();
        if (core_pixel !== e) begin
          errors++;
          $display("FAIL core_pixel: got %0h expected %0h at %0t", core_pixel, e, $time);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] pix;
    logic [6:0]  vmask;
    int          delay;
    logic [3:0]  digit;
    int          rdy_wait;
    logic [3:0]  exp_digit;
    logic        exp_to;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_s_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("s_ready_reached", {31'd0, ok}, 32'd1);
  endtask

  // Drives one full frame; called at a negedge with the block in IDLE.
  task automatic run_frame(input vec_t v);
    int  rst_cnt;
    int  n;
    int  k;
    int  got;
    int  exp_lat;
    int  pulses0;
    bit  prev_hs;
    bit  vbit;
    bit  ok;
    logic [4:0] er;

    pulses0 = ipulse_cnt;
    check("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd1);
    rst_cnt = 0;
    for (int i = 0; i < 20 && !s_ready; i++) begin
      if (core_rst) rst_cnt++;
      @(negedge clk);
    end
    check("core_rst_cycles", rst_cnt, CC);
    wait_s_ready(ok);
    if (!ok) return;

    n = 0;
    k = 0;
    prev_hs = 1'b0;
    while (n < NP && k < 40) begin
      check("i_valid_timing", {31'd0, core_i_valid}, {31'd0, prev_hs});
      check("s_ready_stream", {31'd0, s_ready}, 32'd1);
      vbit = (k < 7) ? v.vmask[k] : 1'b1;
      s_valid = vbit;
      if (vbit) begin
        s_pixel = v.pix[8*n +: 8];
        pix_exp_q.push_back(s_pixel);
        n++;
      end else begin
        s_pixel = DW'($urandom_range(0, 255));
      end
      prev_hs = vbit;
      k++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("last_i_valid", {31'd0, core_i_valid}, 32'd1);
    check("s_ready_wait", {31'd0, s_ready}, 32'd0);

    // core model: answer delay+1 cycles after the last pixel strobe
    res_exp_q.push_back({v.exp_to, v.exp_digit});
    exp_lat = (v.delay < 0) ? TO + 1 : v.delay + 2;
    got = 0;
    for (int c = 1; c <= 40; c++) begin
      if (m_valid) begin
        got = c;
        break;
      end
      core_o_valid = (v.delay >= 0) && (c == v.delay + 1);
      core_digit = core_o_valid ? v.digit : 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    core_o_valid = 1'b0;
    check("result_latency", got, exp_lat);
    if (got == 0) begin
      void'(res_exp_q.pop_front());
      return;
    end

    for (int i = 0; i < v.rdy_wait; i++) begin
      check("held_valid", {31'd0, m_valid}, 32'd1);
      check("held_digit", {28'd0, m_digit}, {28'd0, v.exp_digit});
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    m_ready = 1'b1;
    er = res_exp_q.pop_front();
    check("result_valid", {31'd0, m_valid}, 32'd1);
    check("result_digit", {28'd0, m_digit}, {28'd0, er[3:0]});
    check("result_timeout", {31'd0, m_timeout}, {31'd0, er[4]});
    @(negedge clk);
    m_ready = 1'b0;
    check("post_hs_valid", {31'd0, m_valid}, 32'd0);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
    check("post_hs_no_clear", {31'd0, core_rst}, 32'd0);
    check("frame_pulses", ipulse_cnt - pulses0, NP);
  endtask

  initial begin
    bit ok;
    bit seen;

    vecs[0] = '{pix: 32'h44332211, vmask: 7'b1111111, delay: 2, digit: 4'd7,
                rdy_wait: 0, exp_digit: 4'd7, exp_to: 1'b0};
    vecs[1] = '{pix: $urandom, vmask: 7'b1101001, delay: 0, digit: 4'd2,
                rdy_wait: 0, exp_digit: 4'd2, exp_to: 1'b0};
    vecs[2] = '{pix: $urandom, vmask: 7'b1111111, delay: -1, digit: 4'd0,
                rdy_wait: 0, exp_digit: 4'hF, exp_to: 1'b1};
    vecs[3] = '{pix: $urandom, vmask: 7'b0110101, delay: TO - 1, digit: 4'd3,
                rdy_wait: 0, exp_digit: 4'd3, exp_to: 1'b0};
    vecs[4] = '{pix: $urandom, vmask: 7'b1111111, delay: 4, digit: 4'd9,
                rdy_wait: 10, exp_digit: 4'd9, exp_to: 1'b0};

    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // start and abort together in IDLE: stay idle, no core reset
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_rst", {31'd0, core_rst}, 32'd0);

    // abort after two pixels
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_s_ready(ok);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_pixel = DW'($urandom_range(0, 255));
      pix_exp_q.push_back(s_pixel);
      @(negedge clk);
    end
    s_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_s_ready", {31'd0, s_ready}, 32'd0);
    check("abort_core_rst", {31'd0, core_rst}, 32'd1);
    check("abort_i_valid", {31'd0, core_i_valid}, 32'd0);
    @(negedge clk);
    check("abort_rst_pulse_end", {31'd0, core_rst}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_result", {31'd0, seen}, 32'd0);
    check("abort_queue_empty", pix_exp_q.size(), 0);
    vecs[0].pix = $urandom;
    run_frame(vecs[0]);

    // asynchronous reset mid-stream
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_s_ready(ok);
    s_valid = 1'b1;
    s_pixel = 8'hA5;
    pix_exp_q.push_back(s_pixel);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_s_ready", {31'd0, s_ready}, 32'd0);
    check("arst_core_rst", {31'd0, core_rst}, 32'd0);
    check("arst_i_valid", {31'd0, core_i_valid}, 32'd0);
    check("arst_core_pixel", {24'd0, core_pixel}, 32'd0);
    check("arst_m_valid", {31'd0, m_valid}, 32'd0);
    check("arst_m_digit", {28'd0, m_digit}, 32'd0);
    check("arst_m_timeout", {31'd0, m_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_exp_q.delete();
    @(negedge clk);
    check("arst_release_busy", {31'd0, busy}, 32'd0);
    run_frame(vecs[1]);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
